// File: rtl/audio_pkg.sv
// Shared types and default widths for the audio voice scheduler.
package audio_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_PHASE_W    = 16;
  localparam int DEF_MIX_W      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int vidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Sample-period timebase: counts 0..SAMPLE_DIV-1 while ena is high and
// pulses tick on the final count; ena low freezes the count.
module audio_tick_gen #(
  parameter int SAMPLE_DIV = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int            CW   = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = ena && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audio_voice_scheduler.sv
// Walks all voices once per sample period over the shared datapath, advances phases and mixes samples.
// Optional AUDIO_SCHED_SKIP_EN: ungated voices are passed over without a datapath request.
module audio_voice_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int SAMPLE_DIV = 256,
  parameter int MIX_W      = DEF_MIX_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            cfg_we,
  input  logic [vidx_w(NUM_VOICES)-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0]              cfg_incr,
  input  logic                            cfg_gate,
  output logic                            dp_req,
  output logic [vidx_w(NUM_VOICES)-1:0]   dp_voice,
  output logic [PHASE_W-1:0]              dp_phase,
  input  logic                            dp_ack,
  input  logic [7:0]                      dp_sample,
  output logic [MIX_W-1:0]                mix_out,
  output logic                            mix_valid,
  output logic                            overrun
);

  localparam int            VW     = vidx_w(NUM_VOICES);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

  logic tick;

  audio_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  state_e               state_q, state_d;
  logic [VW-1:0]        ptr_q, ptr_d;
  logic [MIX_W-1:0]     acc_q, acc_d;
  logic [MIX_W-1:0]     mix_q, mix_d;
  logic                 overrun_q, overrun_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [PHASE_W-1:0]   phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]   phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]   incr_q  [NUM_VOICES];
  logic [PHASE_W-1:0]   incr_d  [NUM_VOICES];

  logic cur_gate, skip, req, step;

  assign cur_gate = gate_q[ptr_q];
`ifdef AUDIO_SCHED_SKIP_EN
  assign skip = (state_q == REQ) && !cur_gate;
`else
  assign skip = 1'b0;
`endif
  assign req  = (state_q == REQ) && !skip;
  // A skipped voice consumes its slot exactly like an acked one, so frame length is unchanged.
  assign step = skip || (req && dp_ack);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    mix_d     = mix_q;
    gate_d    = gate_q;
    phase_d   = phase_q;
    incr_d    = incr_q;
    overrun_d = overrun_q | (tick && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (tick) begin
          acc_d   = '0;
          ptr_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (step) begin
          if (req) begin
            phase_d[ptr_q] = phase_q[ptr_q] + incr_q[ptr_q];
            if (cur_gate) acc_d = acc_q + MIX_W'(dp_sample);
          end
          if (ptr_q == LAST_V) begin
            mix_d   = acc_d;
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + VW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Applied after the datapath update so a retrigger overrides a same-cycle increment.
    if (cfg_we) begin
      if (cfg_gate && !gate_q[cfg_voice]) phase_d[cfg_voice] = '0;
      incr_d[cfg_voice] = cfg_incr;
      gate_d[cfg_voice] = cfg_gate;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      overrun_q <= 1'b0;
      gate_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        incr_q[v]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      mix_q     <= mix_d;
      overrun_q <= overrun_d;
      gate_q    <= gate_d;
      phase_q   <= phase_d;
      incr_q    <= incr_d;
    end
  end

  assign dp_req    = req;
  assign dp_voice  = ptr_q;
  assign dp_phase  = phase_q[ptr_q];
  assign mix_out   = mix_q;
  assign mix_valid = (state_q == DONE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Directed plus randomized bench for audio_voice_scheduler with a frame-level reference model.
module tb_audio_voice_scheduler;

  localparam int N   = 4;
  localparam int DIV = 256;
`ifdef AUDIO_SCHED_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ena, cfg_we, cfg_gate, dp_ack;
  logic [1:0]  cfg_voice;
  logic [15:0] cfg_incr;
  logic [7:0]  dp_sample;
  logic        dp_req, mix_valid, overrun;
  logic [1:0]  dp_voice;
  logic [15:0] dp_phase;
  logic [9:0]  mix_out;

  audio_voice_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
    .cfg_incr(cfg_incr), .cfg_gate(cfg_gate), .dp_req(dp_req), .dp_voice(dp_voice),
    .dp_phase(dp_phase), .dp_ack(dp_ack), .dp_sample(dp_sample), .mix_out(mix_out),
    .mix_valid(mix_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: m_pos is -1 between frames, 0..N-1 while voice m_pos is due, N on the result cycle.
  int          m_pos, m_cnt, m_acc, m_mix;
  bit          m_ovr;
  bit          m_gate [N];
  logic [15:0] m_phase [N];
  logic [15:0] m_incr [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_req();
    return (m_pos >= 0) && (m_pos < N) && (!SKIP || m_gate[m_pos]);
  endfunction

  task automatic model_reset();
    m_pos = -1; m_cnt = 0; m_acc = 0; m_mix = 0; m_ovr = 0;
    for (int v = 0; v < N; v++) begin
      m_gate[v] = 0; m_phase[v] = '0; m_incr[v] = '0;
    end
  endtask

  task automatic check_outputs();
    bit r;
    r = m_req();
    chk("dp_req", dp_req, r);
    if (r) begin
      chk("dp_voice", dp_voice, m_pos);
      chk("dp_phase", dp_phase, m_phase[m_pos]);
    end
    chk("mix_valid", mix_valid, m_pos == N);
    chk("mix_out", mix_out, m_mix);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic model_update();
    bit tick, adv;
    int np;
    tick = ena && (m_cnt == DIV - 1);
    np   = m_pos;
    adv  = 0;
    if (ena) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    if (tick && m_pos != -1) m_ovr = 1;
    if (m_pos == -1) begin
      if (tick) begin m_acc = 0; np = 0; end
    end else if (m_pos < N) begin
      if (m_req()) begin
        if (dp_ack) begin
          m_phase[m_pos] = m_phase[m_pos] + m_incr[m_pos];
          if (m_gate[m_pos]) m_acc = m_acc + dp_sample;
          adv = 1;
        end
      end else adv = 1;
      if (adv) begin
        if (m_pos == N - 1) begin np = N; m_mix = m_acc; end
        else np = m_pos + 1;
      end
    end else np = -1;
    if (cfg_we) begin
      if (cfg_gate && !m_gate[cfg_voice]) m_phase[cfg_voice] = '0;
      m_incr[cfg_voice] = cfg_incr;
      m_gate[cfg_voice] = cfg_gate;
    end
    m_pos = np;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p, input int budget, output int taken);
    taken = 0;
    while (m_pos != p && taken < budget) begin
      step();
      taken++;
    end
    if (m_pos != p) begin
      n_cmp++; n_err++;
      $error("FAIL wait_pos_timeout observed=%0d expected=%0d", m_pos, p);
    end
  endtask

  task automatic cfg_write(input int v, input logic [15:0] inc, input logic g);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_incr = inc; cfg_gate = g;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dp_req", dp_req, 0);
    chk("rst_dp_voice", dp_voice, 0);
    chk("rst_dp_phase", dp_phase, 0);
    chk("rst_mix_out", mix_out, 0);
    chk("rst_mix_valid", mix_valid, 0);
    chk("rst_overrun", overrun, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tot;
    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_voice = '0; cfg_incr = '0;
    cfg_gate = 1'b0; dp_ack = 1'b1; dp_sample = 8'h5a;
    model_reset();
    #1;
    do_reset();

    // All gates off: first frame after 256 cycles, empty mix.
    wait_pos(0, 300, t);
    chk("first_tick_cycles", t, 256);
    wait_pos(N, 10, t);
    chk("empty_mix_valid", mix_valid, 1);
    chk("empty_mix_out", mix_out, 0);
    wait_pos(-1, 5, t);

    // Gate all voices with incr v+1 and a constant 0x40 sample.
    for (int v = 0; v < N; v++) cfg_write(v, 16'(v + 1), 1'b1);
    dp_sample = 8'h40;
    wait_pos(N, 300, t);
    chk("mix_256_a", mix_out, 256);
    wait_pos(-1, 5, t);
    wait_pos(N, 300, t);
    chk("mix_256_b", mix_out, 256);
    for (int v = 0; v < N; v++) begin
      wait_pos(v, 300, t);
      chk("phase_two_frames", dp_phase, 2 * (v + 1));
    end
    wait_pos(-1, 10, t);

    // Three-cycle ack stall on voice 2.
    wait_pos(0, 300, t);
    wait_pos(2, 10, tot);
    dp_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tot++;
      chk("stall_voice", dp_voice, 2);
      chk("stall_req", dp_req, 1);
    end
    dp_ack = 1'b1;
    wait_pos(N, 10, t);
    chk("stall_latency", tot + t, N + 3);
    wait_pos(-1, 5, t);

    // Stall long enough for a tick to land mid-frame.
    wait_pos(0, 300, t);
    dp_ack = 1'b0;
    repeat (260) step();
    chk("overrun_set", overrun, 1);
    dp_ack = 1'b1;
    wait_pos(N, 10, t);
    chk("overrun_frame_done", mix_valid, 1);
    repeat (300) step();
    chk("overrun_sticky", overrun, 1);
    wait_pos(-1, 300, t);

    // Retrigger voice 1 in the same cycle it is serviced.
    cfg_write(1, 16'd7, 1'b0);
    wait_pos(1, 300, t);
    cfg_we = 1'b1; cfg_voice = 2'd1; cfg_incr = 16'd9; cfg_gate = 1'b1;
    step();
    cfg_we = 1'b0;
    wait_pos(-1, 10, t);
    wait_pos(1, 300, t);
    chk("retrigger_phase", dp_phase, 0);
    wait_pos(-1, 10, t);

    // Randomized traffic, configuration and enable.
    for (int i = 0; i < 2600; i++) begin
      dp_ack    = ($urandom_range(0, 3) != 0);
      dp_sample = 8'($urandom);
      ena       = ($urandom_range(0, 31) != 0);
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_voice = 2'($urandom_range(0, N - 1));
      cfg_incr  = 16'($urandom);
      cfg_gate  = 1'($urandom);
      step();
    end
    cfg_we = 1'b0; ena = 1'b1; dp_ack = 1'b1;
    wait_pos(-1, 20, t);

    // Enable dropped mid-frame: frame still completes.
    wait_pos(1, 300, t);
    ena = 1'b0;
    wait_pos(N, 10, t);
    chk("ena_low_frame_done", mix_valid, 1);
    repeat (20) step();
    ena = 1'b1;

    // Reset in the middle of a request, then voices 0..2 gated only.
    wait_pos(1, 300, t);
    do_reset();
    for (int v = 0; v < N - 1; v++) cfg_write(v, 16'(3 * v + 1), 1'b1);
    cfg_write(N - 1, 16'd11, 1'b0);
    dp_sample = 8'h21;
    wait_pos(N, 300, t);
    chk("post_reset_mix", mix_out, 3 * 8'h21);
    wait_pos(N - 1, 300, t);
    chk("voice3_req", dp_req, !SKIP);
    wait_pos(-1, 10, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
